// File: rtl/rob_superscalar_pkg.sv
// Shared types for the reorder buffer: entry layout, default field widths
// and the pointer-width helper (index plus one wrap bit).
package rob_superscalar_pkg;

  localparam int ROB_PREG_W = 6;
  localparam int ROB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dest;
    logic [ROB_PREG_W-1:0] dest;
    logic [ROB_PREG_W-1:0] old_dest;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry_t;

  function automatic int rob_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Picks the in-order run of valid+done entries starting at head, up to ALLOC_W lanes.
// Purely combinational, no backpressure: the chain breaks at the first entry not ready.
module rob_commit_select #(
  parameter int DEPTH   = 32,
  parameter int ALLOC_W = 2,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0]         head_idx,
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0]         done,
  output logic [ALLOC_W-1:0]       commit_valid,
  output logic [ALLOC_W*IDX_W-1:0] commit_idx
);

  logic             chain;
  logic [IDX_W-1:0] idx;

  always_comb begin
    chain        = 1'b1;
    idx          = '0;
    commit_valid = '0;
    commit_idx   = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      idx   = head_idx + IDX_W'(i);
      // Entries past tail are never valid, so the chain also stops there.
      chain = chain & valid[idx] & done[idx];
      commit_valid[i]                  = chain;
      commit_idx[i*IDX_W +: IDX_W]     = idx;
    end
  end

endmodule

// File: rtl/rob_superscalar.sv
// Reorder buffer: ALLOC_W in-order allocs, WB_PORTS out-of-order writebacks, ALLOC_W commits/cycle.
// Writeback at edge t is committable in cycle t+1; allocation stalls whole-group when alloc_ready=0.
module rob_superscalar
  import rob_superscalar_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int ALLOC_W  = 2,
  parameter int WB_PORTS = 2,
  parameter int PREG_W   = ROB_PREG_W,
  parameter int DATA_W   = ROB_DATA_W,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic [ALLOC_W-1:0]          alloc_valid,
  input  logic [ALLOC_W-1:0]          alloc_has_dest,
  input  logic [ALLOC_W*PREG_W-1:0]   alloc_dest,
  input  logic [ALLOC_W*PREG_W-1:0]   alloc_old_dest,
  output logic                        alloc_ready,
  output logic [ALLOC_W*IDX_W-1:0]    alloc_idx,
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]   wb_idx,
  input  logic [WB_PORTS*DATA_W-1:0]  wb_value,
  output logic [ALLOC_W-1:0]          commit_valid,
  output logic [ALLOC_W-1:0]          commit_has_dest,
  output logic [ALLOC_W*PREG_W-1:0]   commit_dest,
  output logic [ALLOC_W*PREG_W-1:0]   commit_old_dest,
  output logic [ALLOC_W*DATA_W-1:0]   commit_value,
  output logic [IDX_W:0]              count,
  output logic                        empty
);

  localparam int PTR_W = rob_ptr_w(DEPTH);

  rob_entry_t               entries [DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W-1:0]         free_cnt;
  logic [PTR_W-1:0]         n_alloc;
  logic [PTR_W-1:0]         n_commit;
  logic [DEPTH-1:0]         valid_vec;
  logic [DEPTH-1:0]         done_vec;
  logic [ALLOC_W*IDX_W-1:0] commit_idx;

  // Wrap bit in the pointers makes tail-head span 0..DEPTH without ambiguity.
  assign count       = tail - head;
  assign empty       = (count == '0);
  assign free_cnt    = PTR_W'(DEPTH) - count;
  assign alloc_ready = (free_cnt >= PTR_W'(ALLOC_W));

  always_comb begin
    valid_vec = '0;
    done_vec  = '0;
    for (int e = 0; e < DEPTH; e++) begin
      valid_vec[e] = entries[e].valid;
      done_vec[e]  = entries[e].done;
    end
  end

  rob_commit_select #(
    .DEPTH   (DEPTH),
    .ALLOC_W (ALLOC_W),
    .IDX_W   (IDX_W)
  ) u_commit_select (
    .head_idx     (head[IDX_W-1:0]),
    .valid        (valid_vec),
    .done         (done_vec),
    .commit_valid (commit_valid),
    .commit_idx   (commit_idx)
  );

  always_comb begin
    n_alloc   = '0;
    n_commit  = '0;
    alloc_idx = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_idx[i*IDX_W +: IDX_W] = tail[IDX_W-1:0] + IDX_W'(i);
      if (alloc_ready && alloc_valid[i]) n_alloc = n_alloc + PTR_W'(1);
      if (commit_valid[i])               n_commit = n_commit + PTR_W'(1);
    end
  end

  always_comb begin
    commit_has_dest = '0;
    commit_dest     = '0;
    commit_old_dest = '0;
    commit_value    = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      if (commit_valid[i]) begin
        commit_has_dest[i]                  = entries[commit_idx[i*IDX_W +: IDX_W]].has_dest;
        commit_dest[i*PREG_W +: PREG_W]     = entries[commit_idx[i*IDX_W +: IDX_W]].dest;
        commit_old_dest[i*PREG_W +: PREG_W] = entries[commit_idx[i*IDX_W +: IDX_W]].old_dest;
        commit_value[i*DATA_W +: DATA_W]    = entries[commit_idx[i*IDX_W +: IDX_W]].value;
      end
    end
  end

  // Update order matters: later ports overwrite earlier ones, commit clears after writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      for (int e = 0; e < DEPTH; e++) entries[e] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        entries[e].valid <= 1'b0;
        entries[e].done  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && entries[wb_idx[p*IDX_W +: IDX_W]].valid) begin
          entries[wb_idx[p*IDX_W +: IDX_W]].done  <= 1'b1;
          entries[wb_idx[p*IDX_W +: IDX_W]].value <= wb_value[p*DATA_W +: DATA_W];
        end
      end
      for (int i = 0; i < ALLOC_W; i++) begin
        if (commit_valid[i]) begin
          entries[commit_idx[i*IDX_W +: IDX_W]].valid <= 1'b0;
          entries[commit_idx[i*IDX_W +: IDX_W]].done  <= 1'b0;
        end
      end
      if (alloc_ready) begin
        for (int i = 0; i < ALLOC_W; i++) begin
          if (alloc_valid[i]) begin
            entries[alloc_idx[i*IDX_W +: IDX_W]] <= '{
              valid:    1'b1,
              done:     1'b0,
              has_dest: alloc_has_dest[i],
              dest:     alloc_dest[i*PREG_W +: PREG_W],
              old_dest: alloc_old_dest[i*PREG_W +: PREG_W],
              value:    '0
            };
          end
        end
      end
      head <= head + n_commit;
      tail <= tail + n_alloc;
    end
  end

endmodule

// File: tb/tb_rob_superscalar.sv
// Scoreboard bench for rob_superscalar: allocations push expected entries, commits pop and compare.
module tb_rob_superscalar;

  localparam int DEPTH    = 32;
  localparam int ALLOC_W  = 2;
  localparam int WB_PORTS = 2;
  localparam int PREG_W   = 6;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 5;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic                       flush;
  logic [ALLOC_W-1:0]         alloc_valid;
  logic [ALLOC_W-1:0]         alloc_has_dest;
  logic [ALLOC_W*PREG_W-1:0]  alloc_dest;
  logic [ALLOC_W*PREG_W-1:0]  alloc_old_dest;
  logic                       alloc_ready;
  logic [ALLOC_W*IDX_W-1:0]   alloc_idx;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*IDX_W-1:0]  wb_idx;
  logic [WB_PORTS*DATA_W-1:0] wb_value;
  logic [ALLOC_W-1:0]         commit_valid;
  logic [ALLOC_W-1:0]         commit_has_dest;
  logic [ALLOC_W*PREG_W-1:0]  commit_dest;
  logic [ALLOC_W*PREG_W-1:0]  commit_old_dest;
  logic [ALLOC_W*DATA_W-1:0]  commit_value;
  logic [IDX_W:0]             count;
  logic                       empty;

  rob_superscalar #(
    .DEPTH(DEPTH), .ALLOC_W(ALLOC_W), .WB_PORTS(WB_PORTS),
    .PREG_W(PREG_W), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest),
    .alloc_dest(alloc_dest), .alloc_old_dest(alloc_old_dest),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
    .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
    .commit_dest(commit_dest), .commit_old_dest(commit_old_dest),
    .commit_value(commit_value), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic             has_dest;
    logic [PREG_W-1:0] dest;
    logic [PREG_W-1:0] old_dest;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mv [DEPTH];
  bit          mvalid [DEPTH];
  bit          mdone [DEPTH];
  int          mtail    = 0;
  int          m_alloc  = 0;
  int          m_commit = 0;
  int          checks   = 0;
  int          errors   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) begin
      mvalid[i] = 1'b0;
      mdone[i]  = 1'b0;
    end
    mtail    = 0;
    m_alloc  = 0;
    m_commit = 0;
  endtask

  task automatic alloc(input int n, input logic hd, input logic [PREG_W-1:0] d0, input logic [PREG_W-1:0] d1,
                       input logic [PREG_W-1:0] o0, input logic [PREG_W-1:0] o1);
    bit acc;
    acc            = (DEPTH - (m_alloc - m_commit)) >= ALLOC_W;
    alloc_valid    = (n >= 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    alloc_has_dest = {hd, hd};
    alloc_dest     = {d1, d0};
    alloc_old_dest = {o1, o0};
    tick();
    alloc_valid = '0;
    if (acc) begin
      for (int i = 0; i < n; i++) begin
        sb.push_back('{idx: mtail, has_dest: hd, dest: (i == 0) ? d0 : d1, old_dest: (i == 0) ? o0 : o1});
        mvalid[mtail] = 1'b1;
        mdone[mtail]  = 1'b0;
        mtail         = (mtail + 1) % DEPTH;
        m_alloc++;
      end
    end
  endtask

  task automatic wb(input bit v0, input int i0, input logic [31:0] d0,
                    input bit v1, input int i1, input logic [31:0] d1);
    wb_valid = {v1, v0};
    wb_idx   = {IDX_W'(i1), IDX_W'(i0)};
    wb_value = {d1, d0};
    tick();
    wb_valid = '0;
    if (v0 && mvalid[i0]) begin mv[i0] = d0; mdone[i0] = 1'b1; end
    if (v1 && mvalid[i1]) begin mv[i1] = d1; mdone[i1] = 1'b1; end
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH; k++) begin
      int i;
      i = (mtail + k) % DEPTH;
      if (mvalid[i] && !mdone[i]) wb(1'b1, i, 32'hD000 + i, 1'b0, 0, 32'h0);
    end
  endtask

  task automatic wait_empty(input string tag);
    for (int c = 0; c < 100; c++) begin
      if (empty) break;
      tick();
    end
    check(tag, 64'(empty), 64'd1);
    check({tag, "_count"}, 64'(count), 64'd0);
  endtask

  // Commit monitor: the flush cycle is not a real retirement, so it is skipped.
  always @(negedge clk) begin
    sb_t e;
    if (reset_n && !flush) begin
      for (int i = 0; i < ALLOC_W; i++) begin
        if (commit_valid[i]) begin
          if (sb.size() == 0) begin
            check("commit_spurious", 64'(commit_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            check("commit_has_dest", 64'(commit_has_dest[i]), 64'(e.has_dest));
            check("commit_dest", 64'(commit_dest[i*PREG_W +: PREG_W]), 64'(e.dest));
            check("commit_old_dest", 64'(commit_old_dest[i*PREG_W +: PREG_W]), 64'(e.old_dest));
            check("commit_value", 64'(commit_value[i*DATA_W +: DATA_W]), 64'(mv[e.idx]));
            check("commit_only_done", 64'(mdone[e.idx]), 64'd1);
            mvalid[e.idx] = 1'b0;
            mdone[e.idx]  = 1'b0;
            m_commit++;
          end
        end else begin
          check("idle_lane_value", 64'(commit_value[i*DATA_W +: DATA_W]), 64'd0);
          check("idle_lane_old", 64'(commit_old_dest[i*PREG_W +: PREG_W]), 64'd0);
        end
      end
    end
  end

  initial begin
    int h;
    reset_n        = 1'b0;
    flush          = 1'b0;
    alloc_valid    = '0;
    alloc_has_dest = '0;
    alloc_dest     = '0;
    alloc_old_dest = '0;
    wb_valid       = '0;
    wb_idx         = '0;
    wb_value       = '0;
    for (int i = 0; i < DEPTH; i++) mv[i] = '0;
    model_clear();
    #3;
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(alloc_ready), 64'd1);
    check("rst_commit_valid", 64'(commit_valid), 64'd0);
    check("rst_alloc_idx", 64'(alloc_idx), 64'h20);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic two-lane alloc, writebacks in reverse order.
    alloc(2, 1'b1, 6'd10, 6'd11, 6'd3, 6'd4);
    check("basic_count", 64'(count), 64'd2);
    wb(1'b1, 1, 32'hB, 1'b0, 0, 32'h0);
    check("basic_wait_head", 64'(commit_valid), 64'd0);
    wb(1'b1, 0, 32'hA, 1'b0, 0, 32'h0);
    check("basic_commit2", 64'(commit_valid), 64'd3);
    check("basic_val0", 64'(commit_value[31:0]), 64'hA);
    check("basic_val1", 64'(commit_value[63:32]), 64'hB);
    check("basic_old", 64'(commit_old_dest), 64'({6'd4, 6'd3}));
    tick();
    check("basic_drained", 64'(count), 64'd0);

    // Fill to full, reject extra alloc, then free one and two entries.
    for (int k = 0; k < 16; k++) begin
      alloc(2, 1'b1, 6'(2*k), 6'(2*k+1), 6'(k), 6'(k+16));
      if (k == 14) begin
        check("fill30_count", 64'(count), 64'd30);
        check("fill30_ready", 64'(alloc_ready), 64'd1);
      end
    end
    check("full_count", 64'(count), 64'd32);
    check("full_ready", 64'(alloc_ready), 64'd0);
    check("full_not_empty", 64'(empty), 64'd0);
    alloc(2, 1'b1, 6'd60, 6'd61, 6'd62, 6'd63);
    check("full_ignored", 64'(count), 64'd32);
    check("full_tail_held", 64'(alloc_idx[IDX_W-1:0]), 64'(mtail));
    wb(1'b1, mtail, 32'h100, 1'b0, 0, 32'h0);
    check("full_commit1", 64'(commit_valid), 64'd1);
    tick();
    check("c31_count", 64'(count), 64'd31);
    check("c31_ready", 64'(alloc_ready), 64'd0);
    wb(1'b1, (mtail + 1) % DEPTH, 32'h101, 1'b0, 0, 32'h0);
    check("c30_commit1", 64'(commit_valid), 64'd1);
    tick();
    check("c30_count", 64'(count), 64'd30);
    check("c30_ready", 64'(alloc_ready), 64'd1);
    drain();
    wait_empty("fill_drain");

    // Out-of-order completion: head left incomplete blocks everything behind it.
    h = mtail;
    alloc(2, 1'b1, 6'd1, 6'd2, 6'd7, 6'd8);
    alloc(2, 1'b0, 6'd3, 6'd4, 6'd9, 6'd10);
    alloc(2, 1'b1, 6'd5, 6'd6, 6'd11, 6'd12);
    wb(1'b1, (h+1) % DEPTH, 32'h11, 1'b1, (h+2) % DEPTH, 32'h12);
    wb(1'b1, (h+3) % DEPTH, 32'h13, 1'b1, (h+4) % DEPTH, 32'h14);
    wb(1'b1, (h+5) % DEPTH, 32'h15, 1'b0, 0, 32'h0);
    check("ooo_blocked", 64'(commit_valid), 64'd0);
    check("ooo_count", 64'(count), 64'd6);
    wb(1'b0, 0, 32'h0, 1'b1, h, 32'h10);
    check("ooo_c0", 64'(commit_valid), 64'd3);
    tick();
    check("ooo_c1", 64'(commit_valid), 64'd3);
    tick();
    check("ooo_c2", 64'(commit_valid), 64'd3);
    tick();
    check("ooo_done_count", 64'(count), 64'd0);
    check("ooo_done_cv", 64'(commit_valid), 64'd0);

    // Long single-lane run so the pointers wrap several times.
    for (int k = 0; k < 100; k++) begin
      int idx;
      idx = mtail;
      check("wrap_idx", 64'(alloc_idx[IDX_W-1:0]), 64'(idx));
      check("wrap_ready", 64'(alloc_ready), 64'd1);
      alloc(1, k[0], 6'(k), 6'd0, 6'(63 - (k % 64)), 6'd0);
      wb(1'b1, idx, 32'h5000 + k, 1'b0, 0, 32'h0);
      tick();
      check("wrap_empty", 64'(empty), 64'd1);
    end

    // Two ports completing the same entry: the higher port wins.
    h = mtail;
    alloc(1, 1'b1, 6'd20, 6'd0, 6'd5, 6'd0);
    wb(1'b1, h, 32'h1, 1'b1, h, 32'h2);
    check("dual_wb_value", 64'(commit_value[31:0]), 64'h2);
    tick();

    // Flush with live entries and a concurrent alloc.
    alloc(2, 1'b1, 6'd30, 6'd31, 6'd1, 6'd2);
    alloc(2, 1'b1, 6'd32, 6'd33, 6'd3, 6'd4);
    alloc(1, 1'b1, 6'd34, 6'd0, 6'd5, 6'd0);
    check("pre_flush_count", 64'(count), 64'd5);
    flush          = 1'b1;
    alloc_valid    = 2'b11;
    tick();
    flush          = 1'b0;
    alloc_valid    = '0;
    model_clear();
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_ready", 64'(alloc_ready), 64'd1);
    check("flush_tail", 64'(alloc_idx), 64'h20);
    alloc(1, 1'b1, 6'd40, 6'd0, 6'd41, 6'd0);
    check("flush_next_idx", 64'(alloc_idx[IDX_W-1:0]), 64'd1);
    wb(1'b1, 0, 32'hF00D, 1'b0, 0, 32'h0);
    check("flush_head0", 64'(commit_valid), 64'd1);
    tick();
    check("flush_after_empty", 64'(empty), 64'd1);

    // Asynchronous reset between clock edges.
    alloc(2, 1'b1, 6'd50, 6'd51, 6'd52, 6'd53);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_empty", 64'(empty), 64'd1);
    model_clear();
    #2;
    reset_n = 1'b1;
    tick();
    check("post_rst_idx", 64'(alloc_idx), 64'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
